// File: rtl/jk_cmd_sequencer_if.sv
// Command handshake between a command source and the JK command sequencer.
interface jk_cmd_sequencer_if #(
  parameter int LEN_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [LEN_W-1:0] cmd_len;

  modport master (output cmd_valid, output cmd_op, output cmd_len, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_len, output cmd_ready);
endinterface

// File: rtl/jk_cmd_sequencer.sv
// Queues {op, len} commands and replays each op on the downstream JK flop's j/k,
// while tracking a reference q and flagging any divergence from the fed-back q.
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  jk_cmd_sequencer_if.slave   cmd,
  output logic                j,
  output logic                k,
  input  logic                q_fb,
  output logic                exp_q,
  output logic                done,
  output logic                busy,
  output logic                mismatch
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      PTR_ONE = (AW+1)'(1);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  typedef enum logic { IDLE, RUN } state_t;

  typedef struct packed {
    logic [1:0]       op;
    logic [LEN_W-1:0] len;
  } cmd_t;

  cmd_t             mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             full, empty, push, pop;
  cmd_t             head;
  state_t           state, state_d;
  logic [LEN_W-1:0] rem, rem_d;
  logic             j_d, k_d;

  // The extra MSB on each pointer separates full (MSBs differ) from empty.
  assign empty         = (wr_ptr == rd_ptr);
  assign full          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd.cmd_ready = !full;
  assign push          = cmd.cmd_valid && !full && !reset;
  assign head          = mem[rd_ptr[AW-1:0]];
  assign busy          = (state == RUN) || !empty;

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{op: cmd.cmd_op, len: cmd.cmd_len};
  end

  // NOTE: every sequential block uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rem   <= '0;
      j     <= 1'b0;
      k     <= 1'b0;
    end else begin
      state <= state_d;
      rem   <= rem_d;
      j     <= j_d;
      k     <= k_d;
    end
  end

  // NOTE: all outputs of this block get a default first so no path infers a latch.
  always_comb begin
    state_d = state;
    rem_d   = rem;
    j_d     = j;
    k_d     = k;
    pop     = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        j_d = 1'b0;
        k_d = 1'b0;
        if (!empty) begin
          pop     = 1'b1;
          j_d     = head.op[1];
          k_d     = head.op[0];
          rem_d   = (head.len == '0) ? LEN_ONE : head.len;
          state_d = RUN;
        end
      end
      RUN: begin
        rem_d = rem - LEN_ONE;
        if (rem == LEN_ONE) begin
          done = 1'b1;
          // Back-to-back reload keeps j/k driven with no idle bubble.
          if (!empty) begin
            pop   = 1'b1;
            j_d   = head.op[1];
            k_d   = head.op[0];
            rem_d = (head.len == '0) ? LEN_ONE : head.len;
          end else begin
            j_d     = 1'b0;
            k_d     = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reference q follows the same j/k the downstream flop samples at this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_q    <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      if (q_fb != exp_q) mismatch <= 1'b1;
      case ({j, k})
        2'b01:   exp_q <= 1'b0;
        2'b10:   exp_q <= 1'b1;
        2'b11:   exp_q <= ~exp_q;
        default: exp_q <= exp_q;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Bench for jk_cmd_sequencer: a schedule-based model predicts every cycle's outputs
// while a behavioural JK flop closes the q feedback loop.
module tb_jk_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int LEN_W = 4;

  logic clk, reset;
  logic j, k, q_fb, exp_q, done, busy, mismatch;
  logic flop_q, force_en;

  jk_cmd_sequencer_if #(.LEN_W(LEN_W)) ifc ();

  jk_cmd_sequencer #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd      (ifc),
    .j        (j),
    .k        (k),
    .q_fb     (q_fb),
    .exp_q    (exp_q),
    .done     (done),
    .busy     (busy),
    .mismatch (mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream JK flop.
  always @(posedge clk) begin
    if (reset) flop_q <= 1'b0;
    else case ({j, k})
      2'b01:   flop_q <= 1'b0;
      2'b10:   flop_q <= 1'b1;
      2'b11:   flop_q <= ~flop_q;
      default: flop_q <= flop_q;
    endcase
  end
  assign q_fb = force_en ? 1'b1 : flop_q;

  // Model: each accepted command is pushed at edge p and drives j/k after edges s..s+len-1,
  // where s = max(p+1, end edge of the previous command).
  typedef struct {
    int         p;
    int         s;
    int         len;
    logic [1:0] op;
  } sched_t;

  sched_t sched[$];
  int     n, e_prev;
  logic   m_expq, m_mis;
  int     total, bad;

  function automatic logic [1:0] jk_at(input int t);
    foreach (sched[i]) if (t >= sched[i].s && t < sched[i].s + sched[i].len) return sched[i].op;
    return 2'b00;
  endfunction

  function automatic logic done_at(input int t);
    foreach (sched[i]) if (t == sched[i].s + sched[i].len - 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int occ_at(input int t);
    int c = 0;
    foreach (sched[i]) if (sched[i].p <= t && sched[i].s > t) c++;
    return c;
  endfunction

  function automatic logic busy_at(input int t);
    foreach (sched[i]) if (sched[i].p <= t && t < sched[i].s + sched[i].len) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, n, obs, expv);
    end
  endtask

  task automatic check_outputs();
    logic [1:0] jk;
    jk = jk_at(n);
    check("j", 32'(j), 32'(jk[1]));
    check("k", 32'(k), 32'(jk[0]));
    check("done", 32'(done), 32'(done_at(n)));
    check("busy", 32'(busy), 32'(busy_at(n)));
    check("exp_q", 32'(exp_q), 32'(m_expq));
    check("flop_q", 32'(flop_q), 32'(m_expq));
    check("mismatch", 32'(mismatch), 32'(m_mis));
  endtask

  task automatic step(input logic v, input logic [1:0] op, input int len, output logic acc);
    logic       rdy_m, qfb_now;
    logic [1:0] jk;
    int         s;
    rdy_m = (occ_at(n) < DEPTH);
    check("cmd_ready", 32'(ifc.cmd_ready), 32'(rdy_m));
    ifc.cmd_valid = v;
    ifc.cmd_op    = op;
    ifc.cmd_len   = LEN_W'(len);
    acc = v && rdy_m;
    qfb_now = force_en ? 1'b1 : flop_q;
    if (qfb_now !== m_expq) m_mis = 1'b1;
    jk = jk_at(n);
    case (jk)
      2'b01:   m_expq = 1'b0;
      2'b10:   m_expq = 1'b1;
      2'b11:   m_expq = ~m_expq;
      default: ;
    endcase
    @(posedge clk);
    n++;
    if (acc) begin
      s = (n + 1 > e_prev) ? n + 1 : e_prev;
      sched.push_back('{p: n, s: s, len: (len == 0) ? 1 : len, op: op});
      e_prev = s + ((len == 0) ? 1 : len);
    end
    #1;
    ifc.cmd_valid = 1'b0;
    check_outputs();
  endtask

  task automatic idle(input int cycles);
    logic acc;
    repeat (cycles) step(1'b0, 2'b00, 0, acc);
  endtask

  task automatic push_wait(input logic [1:0] op, input int len);
    logic acc;
    int   tries = 0;
    do begin
      step(1'b1, op, len, acc);
      tries++;
    end while (!acc && tries < 40);
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL push_wait: observed=not accepted after %0d cycles, expected=accepted", tries);
    end
  endtask

  task automatic do_reset(input logic push_in_reset);
    reset         = 1'b1;
    ifc.cmd_valid = push_in_reset;
    ifc.cmd_op    = 2'b11;
    ifc.cmd_len   = LEN_W'(5);
    @(posedge clk);
    n = 0;
    e_prev = 0;
    sched.delete();
    m_expq = 1'b0;
    m_mis  = 1'b0;
    #1;
    reset         = 1'b0;
    ifc.cmd_valid = 1'b0;
    check_outputs();
    check("rst_cmd_ready", 32'(ifc.cmd_ready), 32'd1);
  endtask

  task automatic drain();
    int guard = 0;
    while (busy_at(n) && guard < 200) begin
      idle(1);
      guard++;
    end
    if (guard >= 200) begin
      total++;
      bad++;
      $display("FAIL drain: observed=still busy after %0d cycles, expected=idle", guard);
    end
    idle(2);
  endtask

  initial begin
    logic acc;
    total = 0;
    bad = 0;
    n = 0;
    e_prev = 0;
    m_expq = 1'b0;
    m_mis = 1'b0;
    force_en = 1'b0;
    reset = 1'b1;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_op = 2'b00;
    ifc.cmd_len = '0;
    @(posedge clk);
    do_reset(1'b0);

    // Set for three cycles.
    step(1'b1, 2'b10, 3, acc);
    idle(6);

    // Toggle four times from q=0.
    do_reset(1'b0);
    step(1'b1, 2'b11, 4, acc);
    idle(7);

    // Back-to-back set/clear/toggle, zero-length treated as one below.
    step(1'b1, 2'b10, 1, acc);
    step(1'b1, 2'b01, 2, acc);
    step(1'b1, 2'b11, 1, acc);
    idle(6);
    step(1'b1, 2'b10, 0, acc);
    idle(4);

    // Long hold while the FIFO fills and back-pressures.
    step(1'b1, 2'b00, 15, acc);
    for (int i = 0; i < 5; i++) push_wait(2'(i), i + 1);
    drain();

    // Forced feedback divergence is sticky until reset.
    do_reset(1'b0);
    force_en = 1'b1;
    idle(1);
    force_en = 1'b0;
    idle(3);
    do_reset(1'b0);
    idle(1);

    // Reset mid-command discards the queue and the push in the reset cycle.
    step(1'b1, 2'b11, 8, acc);
    step(1'b1, 2'b10, 2, acc);
    step(1'b1, 2'b01, 3, acc);
    idle(3);
    do_reset(1'b1);
    idle(12);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) == 0) do_reset(1'($urandom_range(1)));
      else step(1'($urandom_range(1)), 2'($urandom_range(3)), int'($urandom_range(6)), acc);
    end
    for (int i = 0; i < 100; i++)
      step(1'($urandom_range(3) == 0), 2'($urandom_range(3)), int'($urandom_range(15)), acc);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jk_cmd_sequencer.md
Name: jk_cmd_sequencer

Overview:
Command sequencer that sits directly upstream of the team's JK flip-flop stage and drives its j/k inputs. It accepts queued {op, length} commands over a valid/ready handshake and replays each op on j/k for the requested number of clock cycles. It keeps a cycle-accurate reference model of the flop's q and compares it against the q fed back from the flop, raising a sticky mismatch flag on any divergence.

Parameters:
DEPTH, 4, command FIFO entries; power of 2, minimum 2.
LEN_W, 4, width of the cmd_len field.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high; also drives the downstream flop's reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  FIFO can accept; equals !full.
cmd_op  input  2  {j,k} op: 00 hold, 01 clear, 10 set, 11 toggle.
cmd_len  input  LEN_W  number of cycles to drive the op; 0 is treated as 1.
j  output  1  registered; to the downstream flop's j input.
k  output  1  registered; to the downstream flop's k input.
q_fb  input  1  q from the downstream flop.
exp_q  output  1  registered reference-model q.
done  output  1  one-cycle pulse on the last drive cycle of each command.
busy  output  1  high when the engine is in RUN or the FIFO is non-empty.
mismatch  output  1  sticky; set when q_fb != exp_q.

Behaviour:
- Reset values: FIFO empty, state IDLE, j=0, k=0, exp_q=0, done=0, mismatch=0, busy=0, cmd_ready=1.
- Push: occurs when cmd_valid && cmd_ready. The FIFO stores {cmd_op, cmd_len}.
- Full FIFO: cmd_ready=0 even if a pop happens in the same cycle; there is no push-through when full.
- Pointers: wrap modulo DEPTH. Full and empty are distinguished by an extra pointer bit.
- Engine FSM has two states, IDLE and RUN.
- IDLE: j=k=0.
  - If the FIFO is non-empty: pop the head, load j,k from op, load remaining = max(len,1), and go to RUN.
  - First-command latency: a command accepted at edge E0 into an empty FIFO with the engine idle has j,k valid after E1.
- RUN: hold j,k at op and decrement remaining each edge.
  - On the last cycle (remaining==1): assert done.
  - If the FIFO is non-empty at that edge: pop and load the next command back-to-back, with no hold bubble.
  - Otherwise: j=k=0 and go to IDLE.
- Reference model: at every edge (not in reset), exp_q updates from the current registered j,k.
  - 00: hold.
  - 01: 0.
  - 10: 1.
  - 11: invert.
  - This matches the flop sampling the same j,k at the same edge.
- Mismatch check: at every edge not in reset, if q_fb != exp_q then mismatch <= 1. Only reset clears it.
- Reset mid-operation: the current command is aborted and queued commands are discarded. All outputs take their reset values at that edge. A push presented in the reset cycle is dropped.
- cmd_len arithmetic: unsigned. The maximum length is 2^LEN_W-1 cycles; the remaining counter is LEN_W bits wide.

Test Plan:
1. Reset, then push op=10 len=3 with q_fb wired to a real JK flop.
   - j=1,k=0 for exactly 3 cycles starting after E1.
   - done pulses on the 3rd cycle.
   - exp_q=q=1; mismatch stays 0.
2. From q=0, push op=11 len=4.
   - exp_q and q go 1,0,1,0.
   - j=k=0 afterwards; busy drops the cycle after done.
3. Push set/len1, clear/len2, toggle/len1 back-to-back.
   - j,k sequence is 10,01,01,11 with no 00 gap.
   - done pulses 3 times; final exp_q=1.
4. Push op=00 len=15, then push 5 more commands on consecutive cycles (DEPTH=4).
   - cmd_ready=0 once 4 are queued; the 5th is held off.
   - After the engine pops, cmd_ready returns to 1 and the 5th is accepted.
5. Force q_fb=1 while exp_q=0.
   - mismatch=1 after the next edge and stays 1 after q_fb is released.
   - Reset clears it.
6. Assert reset for one cycle midway through op=11 len=8 with 2 commands queued.
   - Next cycle: j=k=0, exp_q=0, busy=0, cmd_ready=1, no done.
   - Queued commands are never executed.
